// File: rtl/instr_stream_packer_if.sv
// Loader-to-packer pair handshake plus the instruction-memory write bus.
// Ports: in_valid/in_ready/in_instr/in_imm (pair side), mem_we/mem_addr/mem_data/mem_is_imm (write side).
interface instr_stream_packer_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic [15:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_is_imm;

    // Loader side: offers pairs, observes the write stream.
    modport master (
        output in_valid, in_instr, in_imm,
        input  in_ready, mem_we, mem_addr, mem_data, mem_is_imm
    );

    // Packer side: accepts pairs, drives the memory write port.
    modport slave (
        input  in_valid, in_instr, in_imm,
        output in_ready, mem_we, mem_addr, mem_data, mem_is_imm
    );
endinterface

// File: rtl/instr_stream_packer.sv
// Serializes (instruction, immediate) pairs into 16-bit instruction-memory writes;
// the immediate word follows only when instr[2]=1.
// Ports: clk, rst (sync, active-high), restart, bus (pair in / mem write out),
//        word_count, done (sticky full), overflow (sticky dropped immediate).
module instr_stream_packer #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    instr_stream_packer_if.slave bus,
    output logic [ADDR_W:0]     word_count,
    output logic                done,
    output logic                overflow
);
    typedef enum logic {
        EMIT_INSTR,
        EMIT_IMM
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic [15:0]       imm_q;
    logic              accept;
    logic              at_last;

    // Ready depends only on registers, never on in_valid or data.
    assign bus.in_ready = (state == EMIT_INSTR) && !done;
    assign accept       = bus.in_valid && bus.in_ready;
    // The word about to be written is the final free slot.
    assign at_last      = (word_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state          <= EMIT_INSTR;
            next_addr      <= BASE;
            imm_q          <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= BASE;
            bus.mem_data   <= '0;
            bus.mem_is_imm <= 1'b0;
            word_count     <= '0;
            done           <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            bus.mem_we     <= 1'b0;
            bus.mem_is_imm <= 1'b0;
            unique case (state)
                EMIT_INSTR: begin
                    if (accept) begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= next_addr;
                        bus.mem_data <= bus.in_instr;
                        next_addr    <= next_addr + 1'b1;
                        word_count   <= word_count + 1'b1;
                        if (at_last) begin
                            // No room for a following immediate: drop it.
                            done <= 1'b1;
                            if (bus.in_instr[2]) overflow <= 1'b1;
                        end else if (bus.in_instr[2]) begin
                            imm_q <= bus.in_imm;
                            state <= EMIT_IMM;
                        end
                    end
                end
                EMIT_IMM: begin
                    bus.mem_we     <= 1'b1;
                    bus.mem_is_imm <= 1'b1;
                    bus.mem_addr   <= next_addr;
                    bus.mem_data   <= imm_q;
                    next_addr      <= next_addr + 1'b1;
                    word_count     <= word_count + 1'b1;
                    if (at_last) done <= 1'b1;
                    state          <= EMIT_INSTR;
                end
                default: state <= EMIT_INSTR;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_stream_packer.sv
// Scoreboard bench for instr_stream_packer (BASE_ADDR=0x010, DEPTH=4).
// Expected writes are queued on accept and popped by a write monitor.
module tb_instr_stream_packer;
    localparam int ADDR_W = 12;
    localparam int BASE   = 'h010;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic              is_imm;
        int                cyc;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            restart = 1'b0;
    logic [ADDR_W:0] word_count;
    logic            done;
    logic            overflow;

    instr_stream_packer_if #(.ADDR_W(ADDR_W)) bus ();

    instr_stream_packer #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .restart(restart),
        .bus(bus),
        .word_count(word_count),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;
    wr_t sb[$];
    logic [ADDR_W-1:0] m_addr;
    int m_count;
    logic m_done;
    logic m_ovf;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_addr  = ADDR_W'(BASE);
        m_count = 0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (sb.size() == 0) begin
                check("spurious_write", {16'h0, bus.mem_data}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", 32'(bus.mem_data), 32'(e.data));
                check("wr_is_imm", 32'(bus.mem_is_imm), 32'(e.is_imm));
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic send(input logic [15:0] instr, input logic [15:0] imm,
                        output int waits, output int wcyc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_imm   = imm;
        waits = 0;
        while (!bus.in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        wcyc = cyc + 1;
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        sb.push_back('{m_addr, instr, 1'b0, cyc + 1});
        m_addr++;
        m_count++;
        if (m_count == DEPTH) m_done = 1'b1;
        if (instr[2]) begin
            if (m_count < DEPTH) begin
                sb.push_back('{m_addr, imm, 1'b1, cyc + 2});
                m_addr++;
                m_count++;
                if (m_count == DEPTH) m_done = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_restart();
        @(negedge clk);
        bus.in_valid = 1'b0;
        restart = 1'b1;
        // Writes not yet on the bus are abandoned.
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        @(negedge clk);
        restart = 1'b0;
        model_reset();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_count"}, 32'(word_count), 32'(m_count));
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    int w1, w2, c1, c2, c3;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_imm   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'(BASE));
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check_flags("rst");

        // Back-to-back plain instructions.
        send(16'h0001, 16'h1234, w1, c1);
        send(16'h0008, 16'h5678, w2, c2);
        idle(2);
        check("b2b_ready", 32'(w2), 32'd0);
        check("b2b_gap", 32'(c2 - c1), 32'd1);
        check_flags("b2b");
        do_restart();

        // Immediate stalls the next pair by one cycle.
        send(16'h07FC, 16'hBEEF, w1, c1);
        send(16'h0010, 16'h0000, w2, c2);
        idle(2);
        check("imm_stall", 32'(w2), 32'd1);
        check("imm_gap", 32'(c2 - c1), 32'd2);
        check_flags("imm");
        do_restart();

        // Fill all DEPTH words; last immediate is dropped.
        send(16'h0004, 16'h1111, w1, c1);
        send(16'h0000, 16'h9999, w1, c2);
        send(16'h0004, 16'h2222, w1, c3);
        idle(2);
        check_flags("full");
        check("full_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h0001;
        repeat (3) begin
            @(negedge clk);
            check("full_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        idle(1);
        check_flags("full_hold");
        do_restart();

        // Restart while the immediate is pending.
        send(16'h0004, 16'hAAAA, w1, c1);
        do_restart();
        check("rs_addr", 32'(bus.mem_addr), 32'(BASE));
        check("rs_ready", 32'(bus.in_ready), 32'd1);
        check("rs_we", 32'(bus.mem_we), 32'd0);
        check_flags("rs");
        send(16'h0002, 16'h0000, w1, c1);
        idle(2);
        check_flags("rs_after");

        // rst together with in_valid: no write.
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h0001;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        check("rstv_we", 32'(bus.mem_we), 32'd0);
        check("rstv_addr", 32'(bus.mem_addr), 32'(BASE));
        check_flags("rstv");

        // restart together with an accept: no write.
        @(negedge clk);
        restart = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h0003;
        @(negedge clk);
        restart = 1'b0;
        bus.in_valid = 1'b0;
        check("rsv_we", 32'(bus.mem_we), 32'd0);
        check_flags("rsv");
        idle(2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/instr_stream_packer.md
Name: instr_stream_packer

Overview:
- Producer side of the fetch-stream convention: instructions with bit[2]=1 are followed in memory by one 16-bit immediate word.
- Accepts (instruction, immediate) pairs from the loader/host over a valid/ready handshake. Serializes them into consecutive 16-bit instruction-memory writes: the instruction word, then the immediate word only when instruction bit[2]=1.
- Sits between the program loader and the instruction-memory write port.

Parameters:
- ADDR_W, 12, instruction-memory address width in words.
- BASE_ADDR, 0, first word address written after reset/restart.
- DEPTH, 4096, number of writable words starting at BASE_ADDR (BASE_ADDR+DEPTH <= 2^ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- restart  input  1  sync pulse: rewind to BASE_ADDR, clear flags, abandon pending immediate.
- in_valid  input  1  pair on in_instr/in_imm is valid.
- in_ready  output  1  block can accept a pair this cycle.
- in_instr  input  16  instruction word; bit[2]=1 means an immediate follows.
- in_imm  input  16  immediate word; ignored when in_instr[2]=0.
- mem_we  output  1  write strobe to instruction memory.
- mem_addr  output  ADDR_W  write address.
- mem_data  output  16  write data.
- mem_is_imm  output  1  current write is an immediate word.
- word_count  output  ADDR_W+1  words written since reset/restart.
- done  output  1  sticky; all DEPTH words written.
- overflow  output  1  sticky; an immediate was dropped for lack of space.

Behaviour:
- Reset (rst=1 at edge): state=EMIT_INSTR, next address=BASE_ADDR, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, mem_is_imm=0, word_count=0, done=0, overflow=0, immediate holding register=0.
- Priority at each edge: rst > restart > normal operation.
  - restart does everything rst does. It aborts a pending immediate, which is never written.
- in_ready = (state==EMIT_INSTR) && !done. It is combinational from registers only and never depends on in_valid or data.
- Accept occurs when in_valid && in_ready at an edge.
- All memory-side outputs are registered. A pair accepted at edge N produces mem_we=1 with the instruction word during cycle N..N+1.
- mem_we is high for exactly one cycle per word. mem_we=0 in any cycle with no word to write.
- States:
  - EMIT_INSTR:
    - On accept: write in_instr at the current address and advance the address by 1.
    - If in_instr[2]=1 and space remains: latch in_imm and go to EMIT_IMM.
    - Otherwise stay in EMIT_INSTR.
  - EMIT_IMM:
    - in_ready=0.
    - At the next edge: write the latched immediate with mem_is_imm=1, advance the address, return to EMIT_INSTR.
    - Any new pair is accepted one cycle later.
- Throughput: 1 pair/cycle without immediates; 1 pair per 2 cycles with immediates.
- Address arithmetic:
  - The address advances by 1 per word written.
  - word_count increments by 1 per word written.
  - No wrap: after word_count reaches DEPTH, done=1 in the same cycle as the last write strobe, and in_ready stays 0 until rst/restart.
- Boundary: an instruction with bit[2]=1 accepted at the last free word (word_count==DEPTH-1):
  - The instruction is written.
  - The immediate is dropped.
  - overflow=1 and done=1 are set together.
  - state stays EMIT_INSTR.
- An instruction with bit[2]=0 at the last word sets done only.
- in_valid while in_ready=0 has no effect. The source must hold its data until accepted.
- restart asserted in the same cycle as an accept: restart wins and the pair is not accepted (no write).

Test Plan:
- Reset with BASE_ADDR=0x010: after rst, mem_we=0, mem_addr=0x010, word_count=0, in_ready=1, done=0, overflow=0.
- Back-to-back pairs (0x0001, x), (0x0008, x), in_valid held for 2 cycles -> writes 0x0001@0x010 and 0x0008@0x011 on consecutive cycles, both with mem_is_imm=0, in_ready never low, word_count=2.
- Pair (0x07FC, 0xBEEF), then (0x0010, x) offered immediately:
  - writes 0x07FC@0x010, then 0xBEEF@0x011 with mem_is_imm=1;
  - in_ready=0 for one cycle;
  - 0x0010@0x012 is written one cycle later than it would be without the immediate.
- DEPTH=4, pairs (0x0004,0x1111), (0x0000,x), (0x0004,0x2222):
  - four words written: 0x0004, 0x1111, 0x0000, 0x0004;
  - 0x2222 is not written;
  - done=1, overflow=1, in_ready stays 0, and a further in_valid causes no writes.
- restart during EMIT_IMM after accepting (0x0004, 0xAAAA):
  - 0xAAAA is not written;
  - next cycle mem_addr=BASE_ADDR, word_count=0, in_ready=1;
  - a subsequent pair writes at BASE_ADDR.
- rst and in_valid asserted together -> no write, outputs take their reset values; restart with an accept in the same cycle -> no write.
